// File: rtl/tl_pkg.sv
// TileLink-UL opcode constants and the registered A-channel beat layout
// shared by the tl_ul_initiator slice.
package tl_pkg;

  localparam logic [2:0] GET           = 3'd4;
  localparam logic [2:0] PUTFULL       = 3'd0;
  localparam logic [2:0] PUTPARTIAL    = 3'd1;
  localparam logic [2:0] ACCESSACK     = 3'd0;
  localparam logic [2:0] ACCESSACKDATA = 3'd1;

  localparam logic [2:0] A_PARAM = 3'd0;
  localparam logic [3:0] A_SIZE  = 4'd2;

  // Width-independent A-channel fields; source and address are parameterized
  // per instance and kept beside this struct.
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } a_beat_t;

  function automatic logic [2:0] a_opcode(input logic write, input logic [3:0] mask);
    if (!write)            return GET;
    else if (mask == 4'hF) return PUTFULL;
    else                   return PUTPARTIAL;
  endfunction

endpackage

// File: rtl/tli_id_alloc.sv
// Source-ID allocator: in-flight bitmap with set/clear ports and a
// lowest-free priority encoder that sees the bitmap after this cycle's clear.
module tli_id_alloc #(
  parameter int RS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [RS-1:0]       set_id_i,
  input  logic                clr_i,
  input  logic [RS-1:0]       clr_id_i,
  output logic [RS-1:0]       free_id_o,
  output logic                full_o,
  output logic                busy_o,
  output logic [(1<<RS)-1:0]  inflight_o
);

  localparam int N = 1 << RS;

  logic [N-1:0] map_q, map_d, map_clr;

  always_comb begin
    map_clr = map_q;
    if (clr_i) map_clr[clr_id_i] = 1'b0;
    map_d = map_clr;
    if (set_i) map_d[set_id_i] = 1'b1;
  end

  // Scan downward so the lowest clear bit wins.
  always_comb begin
    free_id_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!map_clr[i]) free_id_o = RS'(i);
    end
  end

  assign full_o     = &map_clr;
  assign busy_o     = |map_q;
  assign inflight_o = map_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) map_q <= '0;
    else         map_q <= map_d;
  end

endmodule

// File: rtl/tl_ul_initiator.sv
// TileLink-UL initiator: command port -> registered A channel, D channel ->
// one-entry response register. Optional watchdog under `TLI_TIMEOUT_EN.
module tl_ul_initiator
  import tl_pkg::*;
#(
  parameter int TL_RS      = 4,
  parameter int TL_AW      = 32,
  parameter int TMO_CYCLES = 1023
) (
  input  logic              tli_clock_i,
  input  logic              tli_reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [TL_AW-1:0]  cmd_address_i,
  input  logic [3:0]        cmd_mask_i,
  input  logic [31:0]       cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_error_o,
  output logic [TL_RS-1:0]  rsp_tag_o,
  output logic [2:0]        tli_a_opcode,
  output logic [2:0]        tli_a_param,
  output logic [3:0]        tli_a_size,
  output logic [TL_RS-1:0]  tli_a_source,
  output logic [TL_AW-1:0]  tli_a_address,
  output logic [3:0]        tli_a_mask,
  output logic [31:0]       tli_a_data,
  output logic              tli_a_corrupt,
  output logic              tli_a_valid,
  input  logic              tli_a_ready,
  input  logic [2:0]        tli_d_opcode,
  input  logic [1:0]        tli_d_param,
  input  logic [3:0]        tli_d_size,
  input  logic [TL_RS-1:0]  tli_d_source,
  input  logic              tli_d_denied,
  input  logic [31:0]       tli_d_data,
  input  logic              tli_d_corrupt,
  input  logic              tli_d_valid,
  output logic              tli_d_ready,
  output logic              err_unexpected_o,
  output logic              timeout_o
);

  localparam int NID = 1 << TL_RS;

  logic             cmd_hs, d_hs, d_known, id_full, id_busy;
  logic [TL_RS-1:0] free_id;
  logic [NID-1:0]   inflight;

  a_beat_t          a_q, a_d;
  logic [TL_RS-1:0] a_src_q, a_src_d;
  logic [TL_AW-1:0] a_addr_q, a_addr_d;
  logic             a_valid_q, a_valid_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [TL_RS-1:0] rsp_tag_q, rsp_tag_d;
  logic             err_unexp_q, err_unexp_d;

  // Shape fields only matter to the slave side; this initiator ignores them.
  logic unused_d_fields;
  assign unused_d_fields = ^{tli_d_opcode, tli_d_param, tli_d_size};

  assign tli_d_ready = !rsp_valid_q || rsp_ready_i;
  assign d_hs        = tli_d_valid && tli_d_ready;
  assign d_known     = inflight[tli_d_source];
  assign cmd_ready_o = (!a_valid_q || tli_a_ready) && !id_full;
  assign cmd_hs      = cmd_valid_i && cmd_ready_o;

  tli_id_alloc #(.RS(TL_RS)) u_alloc (
    .clk_i      (tli_clock_i),
    .rst_ni     (tli_reset_i),
    .set_i      (cmd_hs),
    .set_id_i   (free_id),
    .clr_i      (d_hs && d_known),
    .clr_id_i   (tli_d_source),
    .free_id_o  (free_id),
    .full_o     (id_full),
    .busy_o     (id_busy),
    .inflight_o (inflight)
  );

  always_comb begin
    a_d       = a_q;
    a_src_d   = a_src_q;
    a_addr_d  = a_addr_q;
    a_valid_d = a_valid_q;
    if (cmd_hs) begin
      a_valid_d  = 1'b1;
      a_d.opcode = a_opcode(cmd_write_i, cmd_mask_i);
      a_d.param  = A_PARAM;
      a_d.size   = A_SIZE;
      a_d.mask   = cmd_mask_i;
      a_d.data   = cmd_data_i;
      a_d.corrupt = 1'b0;
      a_src_d    = free_id;
      a_addr_d   = cmd_address_i;
    end else if (tli_a_ready) begin
      a_valid_d = 1'b0;
    end
  end

  // Beats for sources not in flight are swallowed and only flagged.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rsp_tag_d   = rsp_tag_q;
    err_unexp_d = err_unexp_q;
    if (rsp_ready_i) rsp_valid_d = 1'b0;
    if (d_hs) begin
      if (d_known) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = tli_d_data;
        rsp_err_d   = tli_d_denied || tli_d_corrupt;
        rsp_tag_d   = tli_d_source;
      end else begin
        err_unexp_d = 1'b1;
      end
    end
  end

  always_ff @(posedge tli_clock_i or negedge tli_reset_i) begin
    if (!tli_reset_i) begin
      a_q         <= '0;
      a_src_q     <= '0;
      a_addr_q    <= '0;
      a_valid_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tag_q   <= '0;
      err_unexp_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      a_src_q     <= a_src_d;
      a_addr_q    <= a_addr_d;
      a_valid_q   <= a_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tag_q   <= rsp_tag_d;
      err_unexp_q <= err_unexp_d;
    end
  end

  assign tli_a_opcode     = a_q.opcode;
  assign tli_a_param      = a_q.param;
  assign tli_a_size       = a_q.size;
  assign tli_a_mask       = a_q.mask;
  assign tli_a_data       = a_q.data;
  assign tli_a_corrupt    = a_q.corrupt;
  assign tli_a_source     = a_src_q;
  assign tli_a_address    = a_addr_q;
  assign tli_a_valid      = a_valid_q;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_data_o       = rsp_data_q;
  assign rsp_error_o      = rsp_err_q;
  assign rsp_tag_o        = rsp_tag_q;
  assign err_unexpected_o = err_unexp_q;

`ifdef TLI_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;

  // Counter saturates at the limit so the flag cannot be missed by wrap.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (d_hs || !id_busy)                 tmo_cnt_d = '0;
    else if (tmo_cnt_q != TW'(TMO_CYCLES)) tmo_cnt_d = tmo_cnt_q + TW'(1);
    timeout_d = timeout_q || (tmo_cnt_d == TW'(TMO_CYCLES));
  end

  always_ff @(posedge tli_clock_i or negedge tli_reset_i) begin
    if (!tli_reset_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYCLES != 0) || id_busy;
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: tb/tb_tl_ul_initiator.sv
// Self-checking bench for tl_ul_initiator: directed scenarios plus a random
// command/response mix checked against a bitmap-level reference model.
module tb_tl_ul_initiator;
  import tl_pkg::*;

  localparam int TL_RS = 4;
  localparam int TL_AW = 32;
  localparam int NID   = 1 << TL_RS;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [TL_AW-1:0]  cmd_address = '0;
  logic [3:0]        cmd_mask = '0;
  logic [31:0]       cmd_data = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_error;
  logic [31:0]       rsp_data;
  logic [TL_RS-1:0]  rsp_tag;
  logic [2:0]        a_opcode_o, a_param;
  logic [3:0]        a_size, a_mask;
  logic [TL_RS-1:0]  a_source;
  logic [TL_AW-1:0]  a_address;
  logic [31:0]       a_data;
  logic              a_corrupt, a_valid, a_ready = 1'b1;
  logic [2:0]        d_opcode = '0;
  logic [TL_RS-1:0]  d_source = '0;
  logic              d_denied = 1'b0, d_corrupt = 1'b0, d_valid = 1'b0, d_ready;
  logic [31:0]       d_data = '0;
  logic              err_unexp, timeout;

  int checks = 0, errors = 0, a_hs_cnt = 0;
  bit [NID-1:0] model_inflight = '0;

  tl_ul_initiator #(.TL_RS(TL_RS), .TL_AW(TL_AW), .TMO_CYCLES(8)) dut (
    .tli_clock_i(clk), .tli_reset_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_address_i(cmd_address), .cmd_mask_i(cmd_mask), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_error_o(rsp_error), .rsp_tag_o(rsp_tag),
    .tli_a_opcode(a_opcode_o), .tli_a_param(a_param), .tli_a_size(a_size),
    .tli_a_source(a_source), .tli_a_address(a_address), .tli_a_mask(a_mask),
    .tli_a_data(a_data), .tli_a_corrupt(a_corrupt), .tli_a_valid(a_valid),
    .tli_a_ready(a_ready),
    .tli_d_opcode(d_opcode), .tli_d_param(2'd0), .tli_d_size(4'd2),
    .tli_d_source(d_source), .tli_d_denied(d_denied), .tli_d_data(d_data),
    .tli_d_corrupt(d_corrupt), .tli_d_valid(d_valid), .tli_d_ready(d_ready),
    .err_unexpected_o(err_unexp), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (a_valid && a_ready) a_hs_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NID; i++) if (!model_inflight[i]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_opcode(input bit wr, input logic [3:0] m);
    if (!wr) return 3'd4;
    return (m == 4'hF) ? 3'd0 : 3'd1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; #3;
    chk("rst_a_valid", a_valid, 0);    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_unexp", err_unexp, 0); chk("rst_timeout", timeout, 0);
    chk("rst_a_opcode", a_opcode_o, 0); chk("rst_a_address", a_address, 0);
    chk("rst_a_source", a_source, 0);   chk("rst_a_data", a_data, 0);
    chk("rst_a_mask", a_mask, 0);       chk("rst_a_size", a_size, 0);
    chk("rst_rsp_data", rsp_data, 0);   chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_error", rsp_error, 0);
    model_inflight = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One command through the A channel, with a_ready held low for `stall` cycles.
  task automatic issue(input bit wr, input logic [31:0] addr, input logic [3:0] m,
                       input logic [31:0] data, input int stall);
    int n, hs0, src;
    logic [2:0] op;
    src = lowest_free();
    op  = exp_opcode(wr, m);
    a_ready = (stall == 0);
    cmd_write = wr; cmd_address = addr; cmd_mask = m; cmd_data = data; cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 50) begin step(); n++; end
    chk("cmd_ready", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 1'b0; a_ready = 1'b1; return; end
    hs0 = a_hs_cnt;
    step();
    cmd_valid = 1'b0;
    model_inflight[src] = 1'b1;
    for (int c = 0; c <= stall; c++) begin
      chk("a_valid", a_valid, 1);     chk("a_opcode", a_opcode_o, op);
      chk("a_source", a_source, src[TL_RS-1:0]);
      chk("a_address", a_address, addr); chk("a_mask", a_mask, m);
      chk("a_data", a_data, data);     chk("a_param", a_param, 0);
      chk("a_size", a_size, 2);        chk("a_corrupt", a_corrupt, 0);
      if (c < stall) begin chk("cmd_ready_stalled", cmd_ready, 0); step(); end
    end
    a_ready = 1'b1;
    step();
    chk("a_valid_drop", a_valid, 0);
    chk("a_handshakes", a_hs_cnt - hs0, 1);
  endtask

  task automatic respond(input int src, input logic [2:0] op, input logic [31:0] data,
                         input bit den, input bit cor);
    bit known;
    known = model_inflight[src];
    d_source = src[TL_RS-1:0]; d_opcode = op; d_data = data;
    d_denied = den; d_corrupt = cor; d_valid = 1'b1;
    #1;
    chk("d_ready", d_ready, 1);
    step();
    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0;
    if (known) begin
      chk("rsp_valid", rsp_valid, 1); chk("rsp_data", rsp_data, data);
      chk("rsp_tag", rsp_tag, src[TL_RS-1:0]); chk("rsp_error", rsp_error, den | cor);
      model_inflight[src] = 1'b0;
    end else begin
      chk("rsp_valid_unexpected", rsp_valid, 0);
      chk("err_unexpected", err_unexp, 1);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_consumed", rsp_valid, 0);
  endtask

  initial begin
    int q[$];
    int s0;
    do_reset();

    // Read with data response
    issue(1'b0, 32'h10, 4'hF, 32'h0, 0);
    respond(0, ACCESSACKDATA, 32'hDEADBEEF, 1'b0, 1'b0);

    // Partial then full write while the first is still in flight
    issue(1'b1, 32'h20, 4'b0011, 32'h1234, 0);
    issue(1'b1, 32'h24, 4'hF, 32'h5678, 0);
    respond(1, ACCESSACK, 32'h0, 1'b0, 1'b0);
    respond(0, ACCESSACK, 32'h0, 1'b0, 1'b0);

    // Back-to-back commands at full rate
    cmd_write = 1'b0; cmd_mask = 4'hF; cmd_address = 32'h100; cmd_valid = 1'b1; #1;
    chk("b2b_ready0", cmd_ready, 1);
    step();
    cmd_address = 32'h104; #1;
    chk("b2b_ready1", cmd_ready, 1);
    chk("b2b_src0", a_source, 0); chk("b2b_addr0", a_address, 32'h100);
    step();
    cmd_valid = 1'b0;
    chk("b2b_src1", a_source, 1); chk("b2b_addr1", a_address, 32'h104);
    model_inflight[0] = 1'b1; model_inflight[1] = 1'b1;
    step();
    respond(0, ACCESSACKDATA, 32'hA, 1'b0, 1'b0);
    respond(1, ACCESSACKDATA, 32'hB, 1'b0, 1'b0);

    // Fill every ID, free source 5, reuse it
    for (int i = 0; i < NID; i++) issue(1'b0, 32'h1000 + 32'(i * 4), 4'hF, 32'h0, 0);
    #1 chk("full_cmd_ready", cmd_ready, 0);
    respond(5, ACCESSACK, 32'h0, 1'b0, 1'b0);
    issue(1'b0, 32'h2000, 4'hF, 32'h0, 0);
    chk("reuse_src5", a_hs_cnt > 0, 1);
    for (int i = 0; i < NID; i++)
      if (model_inflight[i]) respond(i, ACCESSACKDATA, 32'(i), 1'b0, 1'b0);

    // A-channel backpressure
    issue(1'b1, 32'h3000, 4'b1100, 32'hCAFEF00D, 3);
    respond(0, ACCESSACK, 32'h0, 1'b0, 1'b0);

    // Unexpected source, then denied on a live ID
    respond(7, ACCESSACKDATA, 32'h77, 1'b0, 1'b0);
    issue(1'b0, 32'h40, 4'hF, 32'h0, 0);
    respond(0, ACCESSACKDATA, 32'h55, 1'b1, 1'b0);
    chk("err_unexp_sticky", err_unexp, 1);

    // Random mix against the model
    for (int it = 0; it < 150; it++) begin
      q = {};
      for (int i = 0; i < NID; i++) if (model_inflight[i]) q.push_back(i);
      if (q.size() < NID && (q.size() == 0 || $urandom_range(1, 0) == 0)) begin
        issue(1'($urandom_range(1, 0)), $urandom, 4'($urandom_range(15, 0)), $urandom,
              int'($urandom_range(1, 0)));
      end else begin
        s0 = q[$urandom_range(q.size() - 1, 0)];
        respond(s0, ACCESSACKDATA, $urandom, ($urandom_range(7, 0) == 0),
                ($urandom_range(7, 0) == 0));
      end
    end

    // Reset with a transaction outstanding: its response becomes unexpected
    issue(1'b0, 32'h80, 4'hF, 32'h0, 0);
    s0 = lowest_free() - 1;
    do_reset();
    respond(0, ACCESSACKDATA, 32'h99, 1'b0, 1'b0);
    do_reset();

    // Watchdog
    issue(1'b0, 32'h90, 4'hF, 32'h0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("timeout_early", timeout, 0);
    for (int i = 0; i < 5; i++) step();
`ifdef TLI_TIMEOUT_EN
    chk("timeout_set", timeout, 1);
    respond(0, ACCESSACKDATA, 32'h1, 1'b0, 1'b0);
    chk("timeout_sticky", timeout, 1);
`else
    chk("timeout_tied", timeout, 0);
    respond(0, ACCESSACKDATA, 32'h1, 1'b0, 1'b0);
    chk("timeout_tied_after", timeout, 0);
`endif
    chk("no_unexp_after_reset", err_unexp, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_initiator.md
TL_UL_INITIATOR -- requirements
Module: tl_ul_initiator

Interface
- REQ-001 Parameter TL_RS, default 4: source-ID width; 2^TL_RS transactions may be outstanding.
- REQ-002 Parameter TL_AW, default 32: A-channel address width.
- REQ-003 Parameter TMO_CYCLES, default 1023: watchdog limit, used only when TLI_TIMEOUT_EN is defined.
- REQ-004 Clock and reset:
  - tli_clock_i  in  1  sole clock; all state updates on its rising edge.
  - tli_reset_i  in  1  reset; asynchronous, active-low.
- REQ-005 Command port:
  - cmd_valid_i  in  1  command request.
  - cmd_ready_o  out  1  command accepted.
  - cmd_write_i  in  1  1 = write, 0 = read.
  - cmd_address_i  in  TL_AW  byte address.
  - cmd_mask_i  in  4  byte lanes.
  - cmd_data_i  in  32  write data.
- REQ-006 Response port:
  - rsp_valid_o  out  1  response available.
  - rsp_ready_i  in  1  response consumed.
  - rsp_data_o  out  32  read data.
  - rsp_error_o  out  1  d_denied OR d_corrupt.
  - rsp_tag_o  out  TL_RS  source ID of the response.
- REQ-007 TileLink-UL A channel, all outputs except ready:
  - tli_a_opcode  out  3
  - tli_a_param  out  3
  - tli_a_size  out  4
  - tli_a_source  out  TL_RS
  - tli_a_address  out  TL_AW
  - tli_a_mask  out  4
  - tli_a_data  out  32
  - tli_a_corrupt  out  1
  - tli_a_valid  out  1
  - tli_a_ready  in  1
- REQ-008 TileLink-UL D channel, all inputs except ready:
  - tli_d_opcode  in  3
  - tli_d_param  in  2
  - tli_d_size  in  4
  - tli_d_source  in  TL_RS
  - tli_d_denied  in  1
  - tli_d_data  in  32
  - tli_d_corrupt  in  1
  - tli_d_valid  in  1
  - tli_d_ready  out  1
- REQ-009 Status outputs:
  - err_unexpected_o  out  1  sticky; D response for a source that is not in flight.
  - timeout_o  out  1  sticky watchdog flag.

Function
- REQ-010 The A channel is registered, one entry deep; a command handshake loads it, and tli_a_valid rises on the next cycle (latency 1).
- REQ-011 cmd_ready_o = (!tli_a_valid OR tli_a_ready) AND (a free source ID exists); commands back-to-back at full rate are supported.
- REQ-012 Source allocation: lowest-numbered free ID, taken from an in-flight bitmap; the bit is set on the command handshake.
- REQ-013 Opcode encoding:
  - read: Get (4).
  - write with mask 4'hF: PutFullData (0).
  - write with any other mask: PutPartialData (1).
  - param = 0, size = 2, corrupt = 0 for every opcode.
- REQ-014 A-channel fields are held stable while tli_a_valid=1 and tli_a_ready=0.
- REQ-015 The D channel feeds a one-entry response register:
  - tli_d_ready = !rsp_valid_o OR rsp_ready_i.
  - On a D handshake the register loads data, error and source, and rsp_valid_o rises on the next cycle.
- REQ-016 A D handshake clears the in-flight bit of tli_d_source.
  - A freed ID is reusable in the same cycle; the allocator sees the post-clear bitmap.
- REQ-017 If a D handshake names a source whose bit is clear:
  - the beat is consumed and not forwarded;
  - err_unexpected_o is set and held until reset.
- REQ-018 tli_d_opcode, tli_d_param and tli_d_size are ignored apart from the checks in REQ-017.
- REQ-019 All IDs in flight: cmd_ready_o=0 until a D handshake frees an ID.

Reset
- REQ-020 While tli_reset_i=0, the following are 0:
  - tli_a_valid, rsp_valid_o, the in-flight bitmap, err_unexpected_o, timeout_o and the watchdog counter;
  - all A-channel data fields and rsp_data_o, rsp_error_o, rsp_tag_o.
- REQ-021 Reset mid-transaction drops all tracking; responses arriving after reset are treated as unexpected (REQ-017).

Configuration
- REQ-022 Macro TLI_TIMEOUT_EN defined:
  - A counter increments each cycle while any ID is in flight and no D handshake occurs.
  - A D handshake, or an empty bitmap, clears the counter.
  - When the counter reaches TMO_CYCLES, timeout_o is set (sticky).
- REQ-023 TLI_TIMEOUT_EN undefined: timeout_o is tied to 0 and no counter logic exists.

Structure
- REQ-024 Package tl_pkg holds:
  - opcode constants: GET=4, PUTFULL=0, PUTPARTIAL=1, ACCESSACK=0, ACCESSACKDATA=1;
  - a packed A-channel beat struct.
- REQ-025 One sub-module, tli_id_alloc: bitmap, set/clear ports, lowest-free priority encoder, full flag.

Verification
- REQ-026 The bench covers these directed scenarios:
  - Read at 0x10 with D ready and AccessAckData 0xDEADBEEF -> A: opcode 4, source 0, mask F; then rsp_data_o=0xDEADBEEF, rsp_tag_o=0, rsp_error_o=0.
  - Write with mask 4'b0011, data 0x1234 -> opcode 1; a second write with mask F -> opcode 0 and source 1.
  - 16 reads with no D response (TL_RS=4) -> cmd_ready_o low after the 16th; one AccessAck on source 5 -> next command gets source 5.
  - tli_a_ready held low for 3 cycles -> all A fields stable; exactly one handshake.
  - D beat on source 7 that is not in flight -> no rsp_valid_o, err_unexpected_o=1; d_denied=1 on a valid ID -> rsp_error_o=1.
  - TLI_TIMEOUT_EN with TMO_CYCLES=8: one Get left unanswered -> timeout_o=1 after 8 cycles; stays 1 after a late response.
